// File: rtl/note_phase_acc_if.sv
// note_phase_acc_if: note commands in, per-voice phase words out over valid/ready
interface note_phase_acc_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W = 15
);
  localparam int VW = $clog2(NUM_VOICES);
  logic i_sample_tick;
  logic i_note_on;
  logic i_note_off;
  logic [VW-1:0] i_voice;
  logic [4:0] i_note;
  logic o_valid;
  logic i_ready;
  logic [PHASE_W-1:0] o_phase;
  logic [VW-1:0] o_voice;
  logic o_active;
  logic o_last;
  logic o_err;
  logic o_overrun;
  modport master (
    input i_sample_tick, i_note_on, i_note_off, i_voice, i_note, i_ready,
    output o_valid, o_phase, o_voice, o_active, o_last, o_err, o_overrun
  );
  modport slave (
    output i_sample_tick, i_note_on, i_note_off, i_voice, i_note, i_ready,
    input o_valid, o_phase, o_voice, o_active, o_last, o_err, o_overrun
  );
endinterface

// File: rtl/note_phase_acc.sv
// note_phase_acc: four-voice time-multiplexed phase accumulator feeding the wavetable reader
module note_phase_acc #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W = 15,
  parameter int INC_W = 12
) (
  input logic i_clk,
  input logic i_rst,
  note_phase_acc_if.master bus
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic [INC_W-1:0] INC_TBL [25] = '{
    INC_W'(536), INC_W'(568), INC_W'(601), INC_W'(637), INC_W'(675),
    INC_W'(715), INC_W'(758), INC_W'(803), INC_W'(851), INC_W'(901),
    INC_W'(955), INC_W'(1011), INC_W'(1072), INC_W'(1135), INC_W'(1203),
    INC_W'(1274), INC_W'(1350), INC_W'(1430), INC_W'(1515), INC_W'(1606),
    INC_W'(1701), INC_W'(1802), INC_W'(1909), INC_W'(2023), INC_W'(2143)
  };
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_d;
  logic [PHASE_W-1:0] phase [NUM_VOICES];
  logic [INC_W-1:0] inc [NUM_VOICES];
  logic [NUM_VOICES-1:0] active;
  logic pending, start, hs, fin, load, note_ok;
  logic [VW-1:0] nv;
  always_comb begin
    hs = state == EMIT && bus.o_valid && bus.i_ready;
    fin = hs && bus.o_voice == LAST_V;
    start = state == IDLE && (bus.i_sample_tick || pending);
    load = start || (hs && !fin);
    nv = start ? '0 : bus.o_voice + VW'(1);
    note_ok = bus.i_note_on && bus.i_note <= 5'd24;
    state_d = start ? EMIT : fin ? IDLE : state;
  end
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_d;
  always_ff @(posedge i_clk) begin
    pending <= !i_rst && state == EMIT && (bus.i_sample_tick || pending);
    bus.o_overrun <= !i_rst && (bus.o_overrun || (bus.i_sample_tick && pending));
    bus.o_err <= !i_rst && bus.i_note_on && bus.i_note > 5'd24;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_valid <= 1'b0;
      bus.o_voice <= '0;
      bus.o_phase <= '0;
      bus.o_active <= 1'b0;
      bus.o_last <= 1'b0;
    end else if (load) begin
      bus.o_valid <= 1'b1;
      bus.o_voice <= nv;
      bus.o_phase <= active[nv] ? phase[nv] : '0;
      bus.o_active <= active[nv];
      bus.o_last <= nv == LAST_V;
    end else if (fin) begin
      bus.o_valid <= 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (i_rst) begin
        phase[v] <= '0;
        inc[v] <= '0;
        active[v] <= 1'b0;
      end else if (note_ok && bus.i_voice == VW'(v)) begin
        inc[v] <= INC_TBL[bus.i_note];
        phase[v] <= '0;
        active[v] <= 1'b1;
      end else if (bus.i_note_off && bus.i_voice == VW'(v)) begin
        phase[v] <= '0;
        active[v] <= 1'b0;
      end else if (hs && active[v] && bus.o_voice == VW'(v)) begin
        phase[v] <= phase[v] + PHASE_W'(inc[v]);
      end
    end
  end
endmodule

// File: tb/tb_note_phase_acc.sv
// tb_note_phase_acc: directed vectors and corner-case sequences for note_phase_acc
module tb_note_phase_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  note_phase_acc_if #(.NUM_VOICES(4), .PHASE_W(15)) ifc();
  note_phase_acc #(.NUM_VOICES(4), .PHASE_W(15), .INC_W(12)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(ifc.master)
  );
  typedef struct {
    int voice;
    int note;
    int inc;
    int frames;
    int exp_phase;
  } vec_t;
  vec_t vecs [6];
  int pass_n = 0;
  int total_n = 0;
  int ph [4];
  int ac [4];
  int ls [4];
  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ifc.i_sample_tick = 1'b0;
    ifc.i_note_on = 1'b0;
    ifc.i_note_off = 1'b0;
    ifc.i_voice = '0;
    ifc.i_note = '0;
    ifc.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic cmd(input bit on, input bit off, input int v, input int n);
    ifc.i_note_on = on;
    ifc.i_note_off = off;
    ifc.i_voice = 2'(v);
    ifc.i_note = 5'(n);
    @(negedge clk);
    ifc.i_note_on = 1'b0;
    ifc.i_note_off = 1'b0;
  endtask
  task automatic frame();
    int got = 0;
    int guard = 0;
    for (int k = 0; k < 4; k++) begin
      ph[k] = -1;
      ac[k] = -1;
      ls[k] = -1;
    end
    ifc.i_ready = 1'b1;
    ifc.i_sample_tick = 1'b1;
    @(negedge clk);
    ifc.i_sample_tick = 1'b0;
    while (got < 4 && guard < 40) begin
      if (ifc.o_valid) begin
        ph[ifc.o_voice] = int'(ifc.o_phase);
        ac[ifc.o_voice] = int'(ifc.o_active);
        ls[ifc.o_voice] = int'(ifc.o_last);
        got++;
      end
      @(negedge clk);
      guard++;
    end
    chk("frame_words", got, 4);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    vecs[0] = '{0, 9, 901, 3, 1802};
    vecs[1] = '{2, 24, 2143, 17, 1520};
    vecs[2] = '{1, 0, 536, 2, 536};
    vecs[3] = '{3, 12, 1072, 31, 32160};
    vecs[4] = '{3, 23, 2023, 20, 5669};
    vecs[5] = '{1, 16, 1350, 26, 982};
    do_reset();
    chk("rst_valid", int'(ifc.o_valid), 0);
    chk("rst_phase", int'(ifc.o_phase), 0);
    chk("rst_voice", int'(ifc.o_voice), 0);
    chk("rst_active", int'(ifc.o_active), 0);
    chk("rst_last", int'(ifc.o_last), 0);
    chk("rst_err", int'(ifc.o_err), 0);
    chk("rst_overrun", int'(ifc.o_overrun), 0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      cmd(1'b1, 1'b0, vecs[i].voice, vecs[i].note);
      for (int f = 0; f < vecs[i].frames; f++) begin
        frame();
        chk("vec_step_phase", ph[vecs[i].voice], (f * vecs[i].inc) % 32768);
        chk("vec_step_active", ac[vecs[i].voice], 1);
      end
      chk("vec_final_phase", ph[vecs[i].voice], vecs[i].exp_phase);
      for (int k = 0; k < 4; k++) begin
        chk("vec_last", ls[k], k == 3 ? 1 : 0);
        if (k != vecs[i].voice) begin
          chk("vec_idle_active", ac[k], 0);
          chk("vec_idle_phase", ph[k], 0);
        end
      end
    end
    do_reset();
    ifc.i_ready = 1'b1;
    ifc.i_sample_tick = 1'b1;
    @(negedge clk);
    ifc.i_sample_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("lat_valid", int'(ifc.o_valid), 1);
      chk("lat_voice", int'(ifc.o_voice), k);
      @(negedge clk);
    end
    chk("lat_drop", int'(ifc.o_valid), 0);
    do_reset();
    cmd(1'b1, 1'b0, 1, 4);
    frame();
    ifc.i_ready = 1'b1;
    ifc.i_sample_tick = 1'b1;
    @(negedge clk);
    ifc.i_sample_tick = 1'b0;
    @(negedge clk);
    chk("stall_voice", int'(ifc.o_voice), 1);
    ifc.i_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold_valid", int'(ifc.o_valid), 1);
      chk("stall_hold_voice", int'(ifc.o_voice), 1);
      chk("stall_hold_phase", int'(ifc.o_phase), 675);
      chk("stall_hold_active", int'(ifc.o_active), 1);
    end
    ifc.i_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_voice", int'(ifc.o_voice), 2);
    chk("stall_next_valid", int'(ifc.o_valid), 1);
    repeat (3) @(negedge clk);
    frame();
    chk("stall_advance", ph[1], 1350);
    do_reset();
    ifc.i_sample_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_early", int'(ifc.o_overrun), 0);
    @(negedge clk);
    ifc.i_sample_tick = 1'b0;
    chk("ovr_set", int'(ifc.o_overrun), 1);
    ifc.i_ready = 1'b1;
    cnt = 0;
    repeat (30) begin
      if (ifc.o_valid) cnt++;
      @(negedge clk);
    end
    chk("ovr_words", cnt, 8);
    chk("ovr_sticky", int'(ifc.o_overrun), 1);
    do_reset();
    cmd(1'b1, 1'b0, 0, 9);
    chk("err_quiet", int'(ifc.o_err), 0);
    cmd(1'b1, 1'b0, 2, 25);
    chk("err_pulse", int'(ifc.o_err), 1);
    @(negedge clk);
    chk("err_clear", int'(ifc.o_err), 0);
    frame();
    chk("err_v0_phase", ph[0], 0);
    chk("err_v0_active", ac[0], 1);
    chk("err_v2_active", ac[2], 0);
    frame();
    chk("err_v0_advance", ph[0], 901);
    do_reset();
    cmd(1'b1, 1'b1, 1, 5);
    frame();
    chk("onoff_active", ac[1], 1);
    frame();
    chk("onoff_phase", ph[1], 715);
    do_reset();
    cmd(1'b1, 1'b0, 0, 9);
    frame();
    ifc.i_ready = 1'b0;
    ifc.i_sample_tick = 1'b1;
    @(negedge clk);
    ifc.i_sample_tick = 1'b0;
    chk("off_pre_phase", int'(ifc.o_phase), 901);
    cmd(1'b0, 1'b1, 0, 0);
    chk("off_hold_phase", int'(ifc.o_phase), 901);
    chk("off_hold_active", int'(ifc.o_active), 1);
    chk("off_hold_voice", int'(ifc.o_voice), 0);
    ifc.i_ready = 1'b1;
    repeat (6) @(negedge clk);
    frame();
    chk("off_next_active", ac[0], 0);
    chk("off_next_phase", ph[0], 0);
    do_reset();
    cmd(1'b1, 1'b0, 0, 9);
    frame();
    ifc.i_ready = 1'b1;
    ifc.i_sample_tick = 1'b1;
    @(negedge clk);
    ifc.i_sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_voice", int'(ifc.o_voice), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", int'(ifc.o_valid), 0);
    chk("mid_phase", int'(ifc.o_phase), 0);
    chk("mid_voice_rst", int'(ifc.o_voice), 0);
    chk("mid_active", int'(ifc.o_active), 0);
    chk("mid_last", int'(ifc.o_last), 0);
    chk("mid_overrun", int'(ifc.o_overrun), 0);
    repeat (2) @(negedge clk);
    chk("mid_stays_idle", int'(ifc.o_valid), 0);
    frame();
    for (int k = 0; k < 4; k++) begin
      chk("mid_frame_active", ac[k], 0);
      chk("mid_frame_phase", ph[k], 0);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/note_phase_acc.md
# note_phase_acc

Time-multiplexed, four-voice phase accumulator sitting directly downstream of the note-frequency table in the wave path. A note-on command maps a note index (0 = C5 … 24 = C7) to that note's 12-bit phase increment, which is pre-scaled for a 32768-entry wavetable at a 32 kHz sample rate. On every sample tick the block sweeps all voices and emits each voice's 15-bit wavetable phase over a valid/ready stream to the wavetable reader.

## Interface
- NUM_VOICES, 4, number of voices (power of two, ≥2)
- PHASE_W, 15, phase width; wavetable depth 2^PHASE_W
- INC_W, 12, increment width (table entries fit in 12 bits)
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous and active-high
- i_sample_tick  in  1  one-cycle pulse at 32 kHz
- i_note_on  in  1  one-cycle command: start note i_note on voice i_voice
- i_note_off  in  1  one-cycle command: silence voice i_voice
- i_voice  in  $clog2(NUM_VOICES)  command target voice
- i_note  in  5  note index, 0..24 valid
- o_valid  out  1  phase word available
- i_ready  in  1  downstream accepts word
- o_phase  out  PHASE_W  phase (wavetable address) of presented voice
- o_voice  out  $clog2(NUM_VOICES)  voice number of presented word
- o_active  out  1  presented voice is sounding
- o_last  out  1  presented word is voice NUM_VOICES-1
- o_err  out  1  one-cycle pulse: note-on with i_note > 24, command ignored
- o_overrun  out  1  sticky: a sample tick was dropped; cleared only by reset

## Operation
- Per-voice state: phase[PHASE_W], inc[INC_W], active.
- Increment table (note 0..24): 536, 568, 601, 637, 675, 715, 758, 803, 851, 901, 955, 1011, 1072, 1135, 1203, 1274, 1350, 1430, 1515, 1606, 1701, 1802, 1909, 2023, 2143.
- Note-on (valid note): inc[v] ← table[note], phase[v] ← 0, active[v] ← 1. Invalid note: no state change, o_err pulses the next cycle.
- Note-off: active[v] ← 0, phase[v] ← 0; inc is kept.
- Note-on and note-off in the same cycle: note-on wins.
- Commands are accepted in every FSM state and take effect in the next cycle.
- FSM states:
  - IDLE: on a tick or pending flag, clear pending, set k ← 0, go to EMIT.
  - EMIT: present voice k. On handshake (o_valid & i_ready), if active[k] then phase[k] ← (phase[k] + inc[k]) mod 2^PHASE_W. If k = NUM_VOICES-1, go to IDLE; else k ← k+1 and stay in EMIT.
- Inactive voices are still emitted (o_active=0, o_phase=0), and their phase does not advance.
- The emitted phase is the pre-increment value.
- A handshake-update and a command on the same voice in the same cycle: the command wins.
- A command on the presented voice does not alter o_phase/o_active while the word is held. These outputs are registered at word load.
- A tick arriving outside IDLE sets pending. A tick arriving while pending is already set is dropped and sets o_overrun.
- A tick in IDLE in the same cycle as a pending flag counts as one frame; the extra tick is dropped and sets o_overrun.

## Timing
- Reset values:
  - o_valid=0, o_phase=0, o_voice=0, o_active=0, o_last=0, o_err=0, o_overrun=0
  - every phase=0, inc=0, active=0, pending=0; FSM in IDLE
- Reset mid-sweep: next cycle is IDLE with all state cleared; no partial frame resumes.
- Latency: tick at cycle t in IDLE → o_valid=1 with voice 0 at t+1.
- With i_ready held high, voice k is presented at t+1+k, and o_valid=0 at t+1+NUM_VOICES.
- While o_valid=1 and i_ready=0, o_phase/o_voice/o_active/o_last are stable. o_valid never drops without a handshake.
- Back-to-back words carry no bubble; the next voice is presented in the cycle after the handshake.
- Note-on at cycle c is visible to a word loaded at c+1 or later.

## Test plan
- Reset, note-on voice 0 note 9, ready=1, three ticks → voice-0 phases 0, 901, 1802 with o_active=1; voices 1-3 emit o_active=0, phase 0; o_last high on voice 3 only.
- Note-on voice 2 note 24, 17 ticks → 17th emitted phase = 1520 (wrap: 16·2143 − 32768).
- Tick at t, ready=1 → valid at t+1..t+4 for voices 0..3, low at t+5. Repeat with ready low 5 cycles on voice 1 → voice-1 word held stable; voice 2 follows the cycle after the handshake.
- Ready held low, three ticks during one sweep → first extra tick pending (frame rerun after sweep), second sets o_overrun=1 and it stays set.
- Note-on note 25 → o_err one pulse, voice state unchanged. Simultaneous note-on/off on voice 1 → voice 1 active. Note-off on the presented voice → held word unchanged, the next frame shows o_active=0.
- Assert i_rst during EMIT on voice 2 → next cycle o_valid=0 and all outputs at reset values; next tick emits all voices inactive, phase 0.
